// File: rtl/mfp_input_conditioner.sv
// mfp_input_conditioner
//
// Conditions asynchronous board inputs (slide switches, pushbuttons) before
// they reach the mfp_sys IO inputs. Each channel is synchronised into the
// SI_ClkIn domain, debounced against a shared prescaler tick, and edge
// detected so that downstream logic sees a stable level plus one-cycle
// rise and fall pulses.
//
// Parameters
//   N_CH          number of input channels
//   SYNC_STAGES   flip-flop stages per synchroniser (>= 2)
//   TICK_CYCLES   clocks per debounce tick (1 = tick every clock)
//   STABLE_TICKS  consecutive ticks a new level must persist (>= 1)
//   RESET_VAL     per-channel reset level of synchroniser and db_out
//
// Ports
//   SI_ClkIn      system clock
//   SI_Reset      synchronous active-high reset
//   raw_in        asynchronous pin levels
//   db_out        debounced level per channel
//   rise_pulse    one-cycle pulse when db_out[i] goes 0->1
//   fall_pulse    one-cycle pulse when db_out[i] goes 1->0
//   any_change    registered OR of all rise/fall pulse bits

module mfp_input_conditioner #(
    parameter int              N_CH         = 21,
    parameter int              SYNC_STAGES  = 2,
    parameter int              TICK_CYCLES  = 50000,
    parameter int              STABLE_TICKS = 10,
    parameter logic [N_CH-1:0] RESET_VAL    = {N_CH{1'b0}}
) (
    input  logic            SI_ClkIn,
    input  logic            SI_Reset,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            any_change
);

    localparam int PC_W  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // Synchroniser chain, stage 0 samples the pins, the last stage is s.
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q;
    logic [N_CH-1:0]                  s;

    logic [PC_W-1:0]             pc;
    logic                        tick;

    logic [N_CH-1:0][CNT_W-1:0]  cnt;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_next;
    logic [N_CH-1:0]             accept;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw pins through the synchroniser; new samples enter at
    // stage 0 so every channel sees exactly SYNC_STAGES edges of latency.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Shared prescaler, wrapping from TICK_CYCLES-1 straight back to 0 so
    // tick periods are back to back with no idle cycle between them.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            pc <= '0;
        end else if (pc == PC_LAST) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    // With a single-cycle tick period the compare would always be true
    // anyway; forcing the constant keeps the intent obvious.
    assign tick = (TICK_CYCLES == 1) ? 1'b1 : (pc == PC_LAST);

    // Per-channel qualification. A channel whose synchronised level matches
    // its debounced level drops its count, so any bounce back restarts the
    // qualification from scratch. The accept on the last tick also clears
    // the count, keeping cnt within 0..STABLE_TICKS-1.
    always_comb begin
        cnt_next = cnt;
        accept   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] == db_out[i]) begin
                cnt_next[i] = '0;
            end else if (tick) begin
                if (cnt[i] == CNT_LAST) begin
                    accept[i]   = 1'b1;
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Debounced level and edge pulses. Pulses are only set by an accept in
    // this cycle, so they clear themselves on the next edge; since an
    // accept always flips db_out, rise and fall are mutually exclusive.
    // any_change is built from the registered pulses, one cycle behind.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            db_out     <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            db_out     <= (db_out & ~accept) | (s & accept);
            rise_pulse <= accept & s;
            fall_pulse <= accept & ~s;
            any_change <= |(rise_pulse | fall_pulse);
        end
    end

endmodule

// File: doc/mfp_input_conditioner.md
# mfp_input_conditioner

Parametrised synchroniser, debouncer and edge detector for the asynchronous board inputs: slide switches and pushbuttons. It sits between the board pins and the `mfp_sys` IO inputs (`IO_Switch`, `IO_PB`), replacing direct pin wiring. Unlike the current fixed pin mapping, it handles any channel count and gives each channel a stable level plus one-cycle rise and fall pulses. One shared prescaler serves all channels.

## Interface
- `N_CH`, 21: number of input channels (16 switches + 5 buttons by default).
- `SYNC_STAGES`, 2: flip-flop stages per synchroniser; legal range ≥2.
- `TICK_CYCLES`, 50000: clocks per debounce tick; legal range ≥1; value 1 makes tick permanently high.
- `STABLE_TICKS`, 10: consecutive ticks a new level must persist before it is accepted; legal range ≥1.
- `RESET_VAL`, {N_CH{1'b0}}: per-channel reset value of the synchroniser chain and of `db_out`.
- `SI_ClkIn` input 1: system clock. One clock domain only.
- `SI_Reset` input 1: reset, synchronous, active-high.
- `raw_in` input N_CH: asynchronous pin levels.
- `db_out` output N_CH: debounced level per channel.
- `rise_pulse` output N_CH: one-cycle pulse when `db_out[i]` goes 0→1.
- `fall_pulse` output N_CH: one-cycle pulse when `db_out[i]` goes 1→0.
- `any_change` output 1: registered OR of all `rise_pulse` and `fall_pulse` bits.

## Operation
- **Synchroniser:** per channel, a `SYNC_STAGES`-deep chain. The last stage is `s[i]`.
- **Prescaler:**
  - Counter `pc` of width max(1,clog2(`TICK_CYCLES`)).
  - Counts 0..`TICK_CYCLES`-1 and wraps to 0.
  - `tick` is combinational: high when `pc`==`TICK_CYCLES`-1.
  - When `TICK_CYCLES`==1, `tick` is constant 1.
- **Per-channel counter** `cnt[i]`, width clog2(`STABLE_TICKS`+1). On each clock edge:
  - `s[i]`==`db_out[i]`: `cnt[i]`<=0. Any bounce back to the current level restarts qualification.
  - `s[i]`!=`db_out[i]`, `tick`=0: `cnt[i]` holds.
  - `s[i]`!=`db_out[i]`, `tick`=1, `cnt[i]`<`STABLE_TICKS`-1: `cnt[i]`<=`cnt[i]`+1.
  - `s[i]`!=`db_out[i]`, `tick`=1, `cnt[i]`==`STABLE_TICKS`-1 (accept):
    - `db_out[i]`<=`s[i]` and `cnt[i]`<=0;
    - `rise_pulse[i]`<=`s[i]`, `fall_pulse[i]`<=~`s[i]`.
- **Pulses:** `rise_pulse` and `fall_pulse` are registered and cleared on every edge with no accept. They never exceed 1 cycle. A channel never asserts rise and fall together.
- **Simultaneous events:** channels are fully independent. Several channels may accept on the same tick, and each pulses in the same cycle.
- **`any_change`:** high one cycle after any pulse is high.
- **Reset** (also mid-qualification):
  - synchroniser stages and `db_out` <= `RESET_VAL`;
  - `cnt` and `pc` <= 0;
  - `rise_pulse`, `fall_pulse`, `any_change` <= 0.
  - No pulse is generated by reset itself or by the first post-reset sample if `raw_in` equals `RESET_VAL`.
- **Counter bounds:** `cnt` never exceeds `STABLE_TICKS`-1. The prescaler wraps with no gap.

## Timing
- **Pin to synchroniser output:** `SYNC_STAGES` edges.
- **Acceptance latency** with `TICK_CYCLES`==1: `db_out` changes on edge number `SYNC_STAGES`+`STABLE_TICKS`. Edge 1 is the first edge that samples the new `raw_in` level.
- **Acceptance latency** with `TICK_CYCLES`>1: between (`STABLE_TICKS`-1)·`TICK_CYCLES`+1 and `STABLE_TICKS`·`TICK_CYCLES` edges after `s[i]` changes.
- **Pulse alignment:** `rise_pulse`/`fall_pulse` are high in the same cycle that `db_out` first shows the new value. `any_change` follows one cycle later.
- **Glitch rejection:** any level shorter than `STABLE_TICKS` ticks at `s[i]` produces no output change.

## Test plan
- **Reset values:** `RESET_VAL`=0, `raw_in`=0, hold `SI_Reset` 3 cycles → all outputs 0, no pulses for 20 cycles after release.
- **Clean rise:** `TICK_CYCLES`=1, `STABLE_TICKS`=3, `SYNC_STAGES`=2. `raw_in[0]` 0→1 sampled at edge 1 → `db_out[0]`=1 and `rise_pulse[0]`=1 after edge 5, pulse low after edge 6, `any_change`=1 for the cycle after edge 6 only.
- **Bounce:** same params. `raw_in[3]` pattern 1,1,0,1,1,1,1 per cycle → no change until the final run of 3 stable cycles at `s` completes, then exactly one `rise_pulse[3]`. A 2-cycle high glitch alone gives no pulse.
- **Prescaled timing:** `TICK_CYCLES`=4, `STABLE_TICKS`=2. Step `raw_in[1]` 1→0 at several prescaler phases → `fall_pulse[1]` 5 to 8 edges after `s[1]` changes, each exactly 1 cycle wide.
- **Simultaneous channels:** toggle `raw_in[0]` up and `raw_in[20]` down on the same edge → `rise_pulse[0]` and `fall_pulse[20]` in the same cycle, a single `any_change` cycle.
- **Reset mid-qualification:** assert `SI_Reset` while `cnt[2]`==`STABLE_TICKS`-1 → after reset, `cnt`=0, `db_out[2]`=`RESET_VAL[2]`, no pulse. If `raw_in[2]` stays at the new level, full re-qualification latency applies.
